seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised, multi-cycle shift-add multiplier; the next generation of the team's registered 4x4 multiplier.
- Accepts WIDTH x WIDTH operands over a valid/ready handshake and iterates one partial product per enabled cycle.
- Holds a 2*WIDTH product until the consumer takes it.
- Sits between the tile input pins (or an upstream operand register) and the output mux. Trades latency for area at large WIDTH.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  global enable; when low all state is frozen
- in_valid  input  1  operands a/b present
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid (high only in DONE)
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  result, registered
- op_signed  input  1  present only with SEQ_MULT_SIGNED_EN; 1 = two's-complement operands

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; in_ready=1; out_valid=0; product=0; internal registers=0.
  - Reset mid-operation aborts the operation and discards its result.
- ena low: no state, counter, accumulator or output change; handshakes are ignored (no accept, no release). in_ready and out_valid keep reflecting the current state.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On ena & in_valid: latch a into mcand, b into mplier; acc=0, cnt=0; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each enabled edge: if mplier[0], add mcand into the upper WIDTH+1 bits of acc. Then shift {carry,acc} right one bit, shift mplier right one bit, cnt++.
  - After the WIDTH-th iteration edge: product <= acc; go to DONE.
- DONE:
  - out_valid=1; product stable.
  - On ena & out_ready: go to IDLE. The next operand is accepted no earlier than the following edge (no same-cycle turnaround).
- Latency: fixed. out_valid rises exactly WIDTH enabled edges after the accept edge. Operand values do not shorten latency (0*x still takes WIDTH cycles).
- Throughput: at most one result per WIDTH+2 cycles.
- Arithmetic: unsigned, exact, no truncation; max result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- cnt width is $clog2(WIDTH+1); no wrap-around, because it resets on accept.
- in_valid during BUSY/DONE is ignored. Operands a/b need only be stable on the accept edge.
- product keeps its last value in IDLE and BUSY; it changes only at the BUSY->DONE transition.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - op_signed port exists and is latched on the accept edge.
  - If op_signed=1: operands are converted to magnitudes on accept, and the sign flag is stored as a[MSB]^b[MSB].
  - The 2*WIDTH result is two's-complement negated when that flag is set, folded into the BUSY->DONE product write.
  - Latency is unchanged. -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2), which is representable.
- Undefined: op_signed port absent; unsigned only; no negation logic.

Decomposition:
- Package seq_mult_pkg:
  - state enum typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - localparam for the default width;
  - function for the counter width.
- No sub-module required. Optional sub-module seq_mult_dp may hold acc/mcand/mplier and the adder, with the FSM in the top; the interface is step, load, last.

Test Plan:
- WIDTH=4: a=15, b=15 accepted at edge E0 -> out_valid high after E4, product=225 (0xE1), in_ready=0 during E1..E4.
- WIDTH=8: a=0, b=200 -> product=0 after exactly 8 cycles; then a=255, b=255 -> product=65025 (0xFE01).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
- ena stall: drop ena for 3 cycles mid-BUSY (WIDTH=8, 13*11) -> latency extends by exactly 3, product=143.
- Reset mid-BUSY: assert rst_n=0 asynchronously at iteration 2 -> outputs go to reset values immediately; after release, a new 6*7 yields 42 with normal latency.
- SEQ_MULT_SIGNED_EN, WIDTH=4, op_signed=1:
  - a=-3 (0xD), b=5 -> product=0xF1 (-15);
  - a=-8, b=-8 -> 0x40;
  - op_signed=0, a=0xD, b=5 -> 65.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  // Controller states; encodings are fixed so debug captures stay readable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width used when the instantiating tile does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter width: must hold the values 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult.sv
// seq_mult: multi-cycle shift-add multiplier, one partial product per
// enabled cycle, valid/ready on both sides, product held until taken.
// Build option: define SEQ_MULT_SIGNED_EN to add the op_signed port and
// two's-complement operand support (magnitude multiply + final negate).
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 op_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C    = {{(CW-1){1'b0}}, 1'b1};
`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P    = {{(2*WIDTH-1){1'b0}}, 1'b1};
`endif

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic                 accept;
  logic                 release_ok;
  logic                 last_iter;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   product_final;
  logic [WIDTH-1:0]     mcand_load;
  logic [WIDTH-1:0]     mplier_load;
  logic                 unused_acc_lsb;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign product    = product_reg;

  assign accept     = ena && in_valid && (state_reg == IDLE);
  assign release_ok = ena && out_ready && (state_reg == DONE);
  assign last_iter  = (cnt_reg == LAST_CNT);

  // One iteration: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift {carry, acc} right by one.
  assign addend     = mplier_reg[0] ? mcand_reg : '0;
  assign upper_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next   = {upper_sum, acc_reg[WIDTH-1:1]};
  // The accumulator LSB is shifted out every iteration and never read.
  assign unused_acc_lsb = acc_reg[0];

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_reg;

  // Signed operands are multiplied as magnitudes; -2^(W-1) maps to 2^(W-1).
  assign mcand_load    = (op_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign mplier_load   = (op_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
  assign product_final = neg_reg ? (~acc_next + ONE_P) : acc_next;

  // Result sign captured on accept, applied on the final product write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_reg <= 1'b0;
    end else if (accept) begin
      neg_reg <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`else
  assign mcand_load    = a;
  assign mplier_load   = b;
  assign product_final = acc_next;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; everything holds while ena is low.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (ena && last_iter) state_next = DONE;
      DONE:    if (release_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one shift-add step per enabled
  // BUSY cycle, product captured on the last step only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      mcand_reg   <= mcand_load;
      mplier_reg  <= mplier_load;
      acc_reg     <= '0;
      cnt_reg     <= '0;
    end else if (ena && (state_reg == BUSY)) begin
      acc_reg    <= acc_next;
      mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
      cnt_reg    <= cnt_reg + ONE_C;
      if (last_iter) begin
        product_reg <= product_final;
      end
    end
  end

endmodule
